// File: rtl/hbm_writeback_engine.sv
// hbm_writeback_engine: drains SRAM rows into LANES-word HBM beats.
// Build option HBM_WB_PREFETCH_EN: second row buffer, bubble-free rows.
module hbm_writeback_engine #(
  parameter int WIDTH     = 16,
  parameter int TILE_SIZE = 128,
  parameter int LANES     = 8,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int CNT_W     = 9
) (
  input  logic                       CLK_i,
  input  logic                       RST_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [CNT_W-1:0]           num_rows_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       sram_rd_en_o,
  output logic [ADDR_W-1:0]          sram_addr_o,
  input  logic [TILE_SIZE*WIDTH-1:0] sram_rdata_i,
  output logic                       hbm_valid_o,
  input  logic                       hbm_ready_i,
  output logic [LANES*WIDTH-1:0]     hbm_data_o,
  output logic                       hbm_last_o
);

  localparam int BEATS = TILE_SIZE / LANES;
  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int BW = TILE_SIZE * WIDTH;
  localparam int OW = LANES * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_SEND, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic              xfer, last_beat, rd_en;
  logic [ADDR_W-1:0] rd_addr;
`ifdef HBM_WB_PREFETCH_EN
  logic [BW-1:0]     nxt_q, nxt_d;
  logic              nxt_v_q, nxt_v_d;
  logic              issued_q, issued_d;
`endif

  // next-state, counters, row capture and prefetch issue
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rows_d    = rows_q;
    k_d       = k_q;
    lat_d     = lat_q;
    buf_d     = buf_q;
    rd_en     = 1'b0;
    rd_addr   = addr_q;
    xfer      = (state_q == S_SEND) && hbm_ready_i;
    last_beat = (k_q == KW'(BEATS - 1));
`ifdef HBM_WB_PREFETCH_EN
    nxt_d    = nxt_q;
    nxt_v_d  = nxt_v_q;
    issued_d = issued_q;
`endif
    if (lat_q != '0) lat_d = lat_q - LW'(1);
`ifdef HBM_WB_PREFETCH_EN
    // a read in flight outside WAIT lands in the spare buffer
    if (lat_q == LW'(1) && state_q != S_WAIT) begin
      nxt_d   = sram_rdata_i;
      nxt_v_d = 1'b1;
    end
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rows_d  = num_rows_i;
          state_d = (num_rows_i == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        lat_d   = LW'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LW'(1)) begin
          buf_d   = sram_rdata_i;
          k_d     = '0;
          state_d = S_SEND;
`ifdef HBM_WB_PREFETCH_EN
          issued_d = 1'b0;
        end else if (nxt_v_q && lat_q == '0) begin
          buf_d    = nxt_q;
          nxt_v_d  = 1'b0;
          k_d      = '0;
          issued_d = 1'b0;
          state_d  = S_SEND;
`endif
        end
      end
      S_SEND: begin
`ifdef HBM_WB_PREFETCH_EN
        if (!issued_q) begin
          issued_d = 1'b1;
          if (rows_q > CNT_W'(1)) begin
            rd_en   = 1'b1;
            rd_addr = addr_q + ADDR_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            lat_d   = LW'(RD_LAT);
          end
        end
`endif
        if (xfer) begin
          k_d = k_q + KW'(1);
          if (last_beat) begin
            k_d = '0;
            if (rows_q == CNT_W'(1)) begin
              rows_d  = '0;
              state_d = S_FIN;
            end else begin
              rows_d = rows_q - CNT_W'(1);
`ifdef HBM_WB_PREFETCH_EN
              if (nxt_v_q) begin
                buf_d    = nxt_q;
                nxt_v_d  = 1'b0;
                issued_d = 1'b0;
              end else begin
                state_d = S_WAIT;
              end
`else
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_READ;
`endif
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK_i or negedge RST_i) begin
    if (!RST_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rows_q   <= '0;
      k_q      <= '0;
      lat_q    <= '0;
      buf_q    <= '0;
`ifdef HBM_WB_PREFETCH_EN
      nxt_q    <= '0;
      nxt_v_q  <= 1'b0;
      issued_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rows_q   <= rows_d;
      k_q      <= k_d;
      lat_q    <= lat_d;
      buf_q    <= buf_d;
`ifdef HBM_WB_PREFETCH_EN
      nxt_q    <= nxt_d;
      nxt_v_q  <= nxt_v_d;
      issued_q <= issued_d;
`endif
    end
  end

  assign busy_o = (state_q == S_READ) || (state_q == S_WAIT) ||
                  (state_q == S_SEND);
  assign done_o       = (state_q == S_FIN);
  assign sram_rd_en_o = rd_en;
  assign sram_addr_o  = rd_addr;
  assign hbm_valid_o  = (state_q == S_SEND);
  assign hbm_last_o   = (state_q == S_SEND) && last_beat &&
                        (rows_q == CNT_W'(1));
  assign hbm_data_o   = buf_q[int'(k_q)*OW +: OW];

endmodule

// File: tb/tb_hbm_writeback_engine.sv
// tb_hbm_writeback_engine: scoreboard bench for the HBM writeback engine.
// SRAM model returns word n of row a as {a, n[7:0]}.
module tb_hbm_writeback_engine;

  localparam int BW = 128 * 16;
`ifdef HBM_WB_PREFETCH_EN
  localparam int ROW_GAP = 16;
`else
  localparam int ROW_GAP = 19;
`endif

  logic            CLK_i = 1'b0;
  logic            RST_i = 1'b0;
  logic            start_i = 1'b0;
  logic [7:0]      base_addr_i = '0;
  logic [8:0]      num_rows_i = '0;
  logic            busy_o, done_o, sram_rd_en_o;
  logic [7:0]      sram_addr_o;
  logic [BW-1:0]   sram_rdata_i;
  logic            hbm_valid_o;
  logic            hbm_ready_i = 1'b1;
  logic [127:0]    hbm_data_o;
  logic            hbm_last_o;

  hbm_writeback_engine dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_rows_i(num_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .sram_rd_en_o(sram_rd_en_o), .sram_addr_o(sram_addr_o),
    .sram_rdata_i(sram_rdata_i), .hbm_valid_o(hbm_valid_o),
    .hbm_ready_i(hbm_ready_i), .hbm_data_o(hbm_data_o),
    .hbm_last_o(hbm_last_o)
  );

  always #5 CLK_i = ~CLK_i;

  int cyc = 0;
  always @(posedge CLK_i) cyc <= cyc + 1;

  function automatic logic [BW-1:0] row_data(logic [7:0] a);
    logic [BW-1:0] r;
    for (int n = 0; n < 128; n++) r[n*16 +: 16] = {a, 8'(n)};
    return r;
  endfunction

  function automatic logic [127:0] beat_exp(logic [7:0] a, int k);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = {a, 8'(k*8 + j)};
    return r;
  endfunction

  // SRAM model: data valid exactly two cycles after rd_en
  logic [1:0] pv = '0;
  logic [7:0] pa0 = '0, pa1 = '0;
  always @(posedge CLK_i) begin
    pv  <= {pv[0], sram_rd_en_o};
    pa0 <= sram_addr_o;
    pa1 <= pa0;
  end
  always_comb sram_rdata_i = pv[1] ? row_data(pa1) : {BW{1'b1}};

  // ready pattern 1,0,0,1 when rmode set
  int   rmode = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int pi = 0;
    forever begin
      @(posedge CLK_i);
      #1;
      hbm_ready_i = (rmode != 0) ? pat[pi % 4] : 1'b1;
      pi++;
    end
  end

  int cmp = 0, bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [127:0] exp_d[$];
  logic         exp_l[$];
  logic [7:0]   addr_exp[$];
  int rows_left_exp, beats, rd_cnt, done_cnt, busy_cnt;
  int rd_cyc, done_cyc, start_cyc;
  logic busy_at_done;
  int beat_cyc [64];
  int run, max_run;
  logic         pvld = 1'b0, prdy = 1'b0, plst = 1'b0;
  logic [127:0] pdat = '0;

  task automatic clear_sb();
    exp_d.delete(); exp_l.delete(); addr_exp.delete();
    beats = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    rd_cyc = -1; done_cyc = -1; run = 0; max_run = 0;
    busy_at_done = 1'b1;
  endtask

  // monitor: read-address check, beat scoreboard, hold-stability check
  always @(negedge CLK_i) begin
    if (!RST_i) begin
      pvld = 1'b0;
    end else begin
      if (busy_o) busy_cnt++;
      if (sram_rd_en_o) begin
        rd_cnt++;
        if (rd_cnt == 1) rd_cyc = cyc;
        cmp++;
        assert (addr_exp.size() != 0) else begin
          bad++;
          $error("FAIL rd_unexp observed=%0h expected=none", sram_addr_o);
        end
        if (addr_exp.size() != 0) begin
          logic [7:0] a;
          a = addr_exp.pop_front();
          chk("rd_addr", 128'(sram_addr_o), 128'(a));
          for (int k = 0; k < 16; k++) begin
            exp_d.push_back(beat_exp(a, k));
            exp_l.push_back(rows_left_exp == 1 && k == 15);
          end
          rows_left_exp--;
        end
      end
      if (pvld && !prdy) begin
        chk("hold_valid", 128'(hbm_valid_o), 128'(1));
        chk("hold_data", hbm_data_o, pdat);
        chk("hold_last", 128'(hbm_last_o), 128'(plst));
      end
      run = hbm_valid_o ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (hbm_valid_o && hbm_ready_i) begin
        if (beats < 64) beat_cyc[beats] = cyc;
        cmp++;
        assert (exp_d.size() != 0) else begin
          bad++;
          $error("FAIL beat_unexp observed=%0h expected=none", hbm_data_o);
        end
        if (exp_d.size() != 0) begin
          chk("beat_data", hbm_data_o, exp_d.pop_front());
          chk("beat_last", 128'(hbm_last_o), 128'(exp_l.pop_front()));
        end
        beats++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy_o;
      end
      pvld = hbm_valid_o; prdy = hbm_ready_i;
      pdat = hbm_data_o;  plst = hbm_last_o;
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    clear_sb();
    for (int r = 0; r < int'(n); r++) addr_exp.push_back(b + 8'(r));
    rows_left_exp = int'(n);
    @(negedge CLK_i);
    start_cyc = cyc;
    base_addr_i = b; num_rows_i = n; start_i = 1'b1;
    @(negedge CLK_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge CLK_i); #1; n++;
    end
    cmp++;
    assert (done_cnt != 0) else begin
      bad++;
      $error("FAIL done_timeout observed=%0d expected=1", done_cnt);
    end
  endtask

  task automatic post(input int nb);
    chk("beat_count", 128'(beats), 128'(nb));
    chk("sb_empty", 128'(exp_d.size() + addr_exp.size()), 128'(0));
    chk("done_after_last", 128'(done_cyc - beat_cyc[nb-1]), 128'(1));
    chk("busy_at_done", 128'(busy_at_done), 128'(0));
  endtask

  initial begin
    clear_sb();
    // reset state
    repeat (3) @(negedge CLK_i);
    #1;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_rd_en", 128'(sram_rd_en_o), 128'(0));
    chk("rst_addr", 128'(sram_addr_o), 128'(0));
    chk("rst_valid", 128'(hbm_valid_o), 128'(0));
    chk("rst_last", 128'(hbm_last_o), 128'(0));
    chk("rst_data", hbm_data_o, 128'(0));
    @(negedge CLK_i);
    RST_i = 1'b1;

    // single row
    do_start(8'h10, 9'd1);
    wait_done(60);
    post(16);
    chk("rd_latency", 128'(rd_cyc - start_cyc), 128'(1));
    chk("valid_latency", 128'(beat_cyc[0] - start_cyc), 128'(4));
    chk("rd_count1", 128'(rd_cnt), 128'(1));
    @(negedge CLK_i); #1;
    chk("busy_after", 128'(busy_o), 128'(0));

    // zero rows
    do_start(8'h55, 9'd0);
    wait_done(10);
    chk("zero_done_cyc", 128'(done_cyc - start_cyc), 128'(1));
    chk("zero_reads", 128'(rd_cnt), 128'(0));
    chk("zero_beats", 128'(beats), 128'(0));
    chk("zero_busy", 128'(busy_cnt), 128'(0));

    // backpressure, two rows
    rmode = 1;
    do_start(8'h30, 9'd2);
    wait_done(300);
    post(32);
    rmode = 0;

    // address wrap, two rows at full rate
    do_start(8'hFF, 9'd2);
    wait_done(100);
    post(32);
    chk("wrap_row_gap", 128'(beat_cyc[16] - beat_cyc[0]), 128'(ROW_GAP));

    // three rows: streaming cadence
    do_start(8'h80, 9'd3);
    wait_done(150);
    post(48);
    chk("row_gap_1", 128'(beat_cyc[16] - beat_cyc[0]), 128'(ROW_GAP));
    chk("row_gap_2", 128'(beat_cyc[32] - beat_cyc[16]), 128'(ROW_GAP));
`ifdef HBM_WB_PREFETCH_EN
    chk("pf_run", 128'(max_run), 128'(48));
`endif

    // reset during beat 5 of row 0
    do_start(8'h40, 9'd2);
    begin
      int n = 0;
      while (beats < 5 && n < 50) begin
        @(negedge CLK_i); #1; n++;
      end
    end
    chk("reach_beat5", 128'(beats), 128'(5));
    RST_i = 1'b0;
    #1;
    chk("arst_busy", 128'(busy_o), 128'(0));
    chk("arst_valid", 128'(hbm_valid_o), 128'(0));
    chk("arst_last", 128'(hbm_last_o), 128'(0));
    chk("arst_data", hbm_data_o, 128'(0));
    chk("arst_rd", 128'(sram_rd_en_o), 128'(0));
    chk("arst_addr", 128'(sram_addr_o), 128'(0));
    clear_sb();
    repeat (3) @(negedge CLK_i);
    RST_i = 1'b1;
    repeat (3) @(negedge CLK_i);
    #1;
    chk("arst_no_done", 128'(done_cnt), 128'(0));

    // restart with a start pulse while busy
    do_start(8'h20, 9'd1);
    @(negedge CLK_i);
    base_addr_i = 8'h99; num_rows_i = 9'd7; start_i = 1'b1;
    @(negedge CLK_i);
    start_i = 1'b0;
    wait_done(60);
    post(16);
    repeat (4) @(negedge CLK_i);
    #1;
    chk("ign_rd_count", 128'(rd_cnt), 128'(1));
    chk("ign_busy", 128'(busy_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/hbm_writeback_engine.md
Name: hbm_writeback_engine

Overview:
- Drains result tiles from one SRAM bank back toward HBM2e.
- Reads whole SRAM rows (TILE_SIZE words each) at consecutive addresses.
- Serializes each row into LANES-word beats on a valid/ready stream to the HBM write port.
- One instance per SRAM bank on the output side of the memory controller. It is the reader/transmitter counterpart of the HBM-to-SRAM fill path.

Parameters:
- WIDTH, 16, bits per data word
- TILE_SIZE, 128, words per SRAM row
- LANES, 8, words per HBM beat; TILE_SIZE must be a multiple of LANES
- ADDR_W, 8, SRAM row address width
- RD_LAT, 2, SRAM read latency in cycles, minimum 1
- CNT_W, 9, width of the row-count field

Ports:
- CLK_i  in  1  clock; all state updates on the rising edge
- RST_i  in  1  asynchronous, active-low reset
- start_i  in  1  command strobe; sampled only in IDLE
- base_addr_i  in  ADDR_W  first SRAM row to drain
- num_rows_i  in  CNT_W  number of rows to drain
- busy_o  out  1  high from the accepted start until done
- done_o  out  1  one-cycle pulse when the command completes
- sram_rd_en_o  out  1  SRAM read strobe
- sram_addr_o  out  ADDR_W  SRAM read row address
- sram_rdata_i  in  TILE_SIZE*WIDTH  SRAM row data; valid exactly RD_LAT cycles after rd_en
- hbm_valid_o  out  1  beat valid
- hbm_ready_i  in  1  HBM write port ready
- hbm_data_o  out  LANES*WIDTH  beat payload; word 0 in the LSBs
- hbm_last_o  out  1  marks the final beat of the command

Behaviour:
- Reset (RST_i low, asynchronous):
  - FSM goes to IDLE.
  - busy_o, done_o, sram_rd_en_o, hbm_valid_o and hbm_last_o are 0.
  - sram_addr_o, hbm_data_o and all counters are 0.
  - Reset mid-command aborts it: no done_o pulse, and the partial row buffer is discarded.
- IDLE:
  - start_i=1 latches base_addr_i and num_rows_i.
  - If num_rows_i==0: go to FINISH (no SRAM reads, no beats).
  - Otherwise: go to READ.
  - start_i is ignored in every state except IDLE.
- READ:
  - sram_rd_en_o=1 for exactly one cycle, with sram_addr_o = current address.
  - Then go to WAIT with a latency counter set to RD_LAT.
- WAIT:
  - Counter decrements each cycle.
  - The row is captured into the row buffer exactly RD_LAT cycles after the rd_en cycle.
  - Then go to SEND with beat index 0.
- SEND:
  - hbm_valid_o=1; hbm_data_o = row buffer words [k*LANES +: LANES], k = beat index.
  - A transfer occurs when valid and ready are both 1; k then increments.
  - While ready=0, data and last are held stable and valid is never dropped.
  - On the transfer of the last beat of a row (k = TILE_SIZE/LANES-1):
    - If rows remain: increment the address and go to READ.
    - Otherwise: go to FINISH.
  - hbm_last_o=1 only on the last beat of the last row.
- FINISH: done_o=1 for one cycle, busy_o drops in the same cycle, then go to IDLE.
- busy_o is 1 in READ, WAIT and SEND.
- Address increments modulo 2^ADDR_W; wrap from 255 to 0 is legal and silent.
- Latency, with start accepted in cycle 0:
  - rd_en in cycle 1.
  - First hbm_valid_o in cycle 2+RD_LAT.
- Throughput without prefetch:
  - One row costs TILE_SIZE/LANES beats plus 1+RD_LAT bubble cycles.
  - With LANES=8 that is 16 beats per row, 19 cycles total at RD_LAT=2.
- The SRAM is never read while a beat from the previous row is outstanding (without prefetch).

Optional Feature:
- Macro: HBM_WB_PREFETCH_EN.
- When defined:
  - A second row buffer is added.
  - The next row's read is issued on the first SEND cycle of the current row (if rows remain).
  - The captured row is swapped in after the current row's last beat transfers.
  - Back-to-back rows then stream with no bubble while hbm_ready_i stays 1.
  - Beat order, last and done timing relative to the final beat are unchanged.
  - Reset clears both buffers.
- When undefined: single buffer, and the bubble timing above applies.

Test Plan:
- Basic single row:
  - Stimulus: reset, start with base=0x10, rows=1, ready held 1, SRAM word n = n.
  - Response: rd_en at cycle 1 with addr 0x10; valid at cycle 4; 16 beats with beat k words = 8k..8k+7; last on beat 15; done one cycle after beat 15; busy low afterwards.
- Zero rows:
  - Stimulus: start with rows=0.
  - Response: no rd_en, no valid; done pulse in cycle 1; busy never asserted beyond that.
- Backpressure:
  - Stimulus: rows=2, ready toggled 1,0,0,1 repeatedly.
  - Response: data and last stable during ready=0; 32 beats total in order; addresses base, base+1; last only on beat 31.
- Address wrap:
  - Stimulus: base=0xFF, rows=2.
  - Response: reads at 0xFF then 0x00; done after 32 beats.
- Reset and ignored start:
  - Stimulus: RST_i low during beat 5 of row 0, then re-start with rows=1.
  - Response: all outputs 0 immediately; no done; clean 16-beat run afterwards. A start_i pulse during busy is ignored, with no change to count or address.
- Prefetch (HBM_WB_PREFETCH_EN):
  - Stimulus: rows=3, ready=1.
  - Response: 48 consecutive valid cycles with no gaps; done one cycle after beat 47.
